ir_key_ctrl: RTL



---
 rtl/ir_pkg.sv | 35 +++
 rtl/ir_evt_fifo.sv | 70 +++++++
 rtl/ir_key_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared constants for the NEC IR key controller: event codes, NEC field slices, timer sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ir_pkg;

  // Event type encoding carried in the upper bits of each FIFO word.
  localparam int         EVT_W       = 2;
  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_REPEAT  = 2'd1;
  localparam logic [1:0] EVT_RELEASE = 2'd2;

  // NEC frame_data layout: command in the low byte, its complement in the high byte.
  localparam int KEY_W   = 8;
  localparam int CMD_LSB = 0;
  localparam int INV_LSB = 8;

  // Release timeout in clock cycles.
  function automatic int hold_cycles(input int clk_hz, input int hold_ms);
    return (clk_hz / 1000) * hold_ms;
  endfunction

  // Timer width: must be able to hold the full reload value.
  function automatic int timer_width(input int clk_hz, input int hold_ms);
    int w;
    w = $clog2(hold_cycles(clk_hz, hold_ms) + 1);
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_SWITCH = 2'd2
  } key_state_t;

endpackage

// File: rtl/ir_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for key events.
// Latency: a word pushed on edge N is visible on head_dat in cycle N+1.
// Backpressure: push while full is accepted only if a pop happens in the same cycle; otherwise it is dropped.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   push, push_dat      - write request and data
//   pop                 - consume head word (ignored when empty)
//   head_dat            - head word, zero while empty
//   full, empty         - occupancy flags
module ir_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  // DEPTH is a power of two (>= 2), so the pointers wrap naturally.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot at wr_ptr is the head being popped this cycle, so overwriting it is safe.
  assign do_push = push && (!full || do_pop);

  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ir_key_ctrl.sv
// NEC IR key controller: filters decoded frames/repeats into PRESS/REPEAT/RELEASE events.
// Latency: an event pushed on the edge ending cycle N is presented on evt_* in cycle N+1.
// Backpressure: evt_valid/evt_ready; if the event FIFO is full without a pop the event is dropped and overflow sticks.
//
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   frame_valid/addr/data           - decoded NEC frame pulse, address, {~cmd, cmd}
//   repeat_valid                    - NEC repeat-code pulse
//   evt_valid/ready/type/key        - event stream toward the consumer
//   key_held                        - a key is currently considered held
//   err_cnt                         - saturating count of rejected frames
//   overflow                        - sticky event-drop flag
module ir_key_ctrl
  import ir_pkg::*;
#(
  parameter int          CLK_HZ       = 50_000_000,
  parameter logic [15:0] DEV_ADDR     = 16'h0001,
  parameter int          ADDR_CHECK   = 1,
  parameter int          HOLD_MS      = 120,
  parameter int          REPEAT_DELAY = 3,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [15:0] frame_addr,
  input  logic [15:0] frame_data,
  input  logic        repeat_valid,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_type,
  output logic [7:0]  evt_key,
  output logic        key_held,
  output logic [7:0]  err_cnt,
  output logic        overflow
);

  localparam int             HOLD_CYC  = hold_cycles(CLK_HZ, HOLD_MS);
  localparam int             TW        = timer_width(CLK_HZ, HOLD_MS);
  localparam logic [TW-1:0]  HOLD_LOAD = TW'(HOLD_CYC);
  localparam logic [7:0]     REP_DLY   = 8'(REPEAT_DELAY);
  localparam int             FW        = EVT_W + KEY_W;

  // Frame qualification
  logic [KEY_W-1:0] cmd;
  logic [KEY_W-1:0] inv;
  logic             addr_ok;
  logic             frame_good;
  logic             frame_bad;

  assign cmd        = frame_data[CMD_LSB +: KEY_W];
  assign inv        = frame_data[INV_LSB +: KEY_W];
  assign addr_ok    = (ADDR_CHECK == 0) || (frame_addr == DEV_ADDR);
  assign frame_good = frame_valid && (inv == ~cmd) && addr_ok;
  assign frame_bad  = frame_valid && !frame_good;

  // FSM state and datapath registers
  key_state_t       state_q, state_n;
  logic [KEY_W-1:0] key_q, key_n;
  logic [TW-1:0]    timer_q, timer_n;
  logic [7:0]       rep_q, rep_n;

  logic             push;
  logic [EVT_W-1:0] push_type;
  logic [KEY_W-1:0] push_key;
  logic             reload;

  // A bad frame still owns the cycle, so a coincident repeat pulse is ignored.
  assign reload = (frame_good && (cmd == key_q)) || (!frame_valid && repeat_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      timer_q <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_n;
      key_q   <= key_n;
      timer_q <= timer_n;
      rep_q   <= rep_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    key_n     = key_q;
    timer_n   = timer_q;
    rep_n     = rep_q;
    push      = 1'b0;
    push_type = EVT_PRESS;
    push_key  = key_q;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_good) begin
          push      = 1'b1;
          push_type = EVT_PRESS;
          push_key  = cmd;
          key_n     = cmd;
          timer_n   = HOLD_LOAD;
          rep_n     = '0;
          state_n   = ST_HELD;
        end
      end

      ST_HELD: begin
        if (reload) begin
          // Reload beats expiry in the same cycle, so no RELEASE here.
          timer_n = HOLD_LOAD;
          if (rep_q != 8'hFF) begin
            rep_n = rep_q + 8'd1;
          end
          if (rep_q >= REP_DLY) begin
            push      = 1'b1;
            push_type = EVT_REPEAT;
          end
        end else if (frame_good) begin
          push      = 1'b1;
          push_type = EVT_RELEASE;
          key_n     = cmd;
          state_n   = ST_SWITCH;
        end else if (timer_q <= TW'(1)) begin
          // Last cycle of the hold window: the decrement would reach zero.
          push      = 1'b1;
          push_type = EVT_RELEASE;
          timer_n   = '0;
          state_n   = ST_IDLE;
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end

      ST_SWITCH: begin
        // key_q already holds the new key; inputs are ignored for this cycle.
        push      = 1'b1;
        push_type = EVT_PRESS;
        timer_n   = HOLD_LOAD;
        rep_n     = '0;
        state_n   = ST_HELD;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Event FIFO
  logic [FW-1:0] head_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic          evt_pop;

  assign evt_pop = evt_valid && evt_ready;

  ir_evt_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({push_type, push_key}),
    .pop      (evt_ready),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign evt_valid           = !fifo_empty;
  assign {evt_type, evt_key} = head_dat;
  assign key_held            = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (frame_bad && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (push && fifo_full && !evt_pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
